// File: rtl/glitch_detector.sv
// Lockstep comparator: realigns the primary stream to the lagging shadow core,
// compares every armed cycle and escalates repeated mismatches to a sticky alarm.
module glitch_detector #(
    parameter int DATA_WIDTH = 32,
    parameter int DELAY      = 2,
    parameter int THRESHOLD  = 3,
    parameter int WINDOW     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] primary_data,
    input  logic                  primary_valid,
    input  logic [DATA_WIDTH-1:0] shadow_data,
    input  logic                  shadow_valid,
    input  logic                  clear,
    output logic                  mismatch,
    output logic                  alarm,
    output logic                  suspect,
    output logic [7:0]            fault_count,
    output logic [DATA_WIDTH-1:0] syndrome
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        SUSPECT = 2'd2,
        ALARM   = 2'd3
    } state_t;

    localparam logic [3:0] ARM_DONE    = 4'(DELAY);
    localparam logic [3:0] THRESH_L    = 4'(THRESHOLD);
    localparam logic [7:0] WINDOW_LAST = 8'(WINDOW - 1);

    logic [DATA_WIDTH-1:0] line_data_reg  [DELAY];
    logic                  line_valid_reg [DELAY];
    logic [3:0]            arm_count_reg;

    state_t                state_reg, state_next;
    logic [3:0]            streak_reg, streak_next;
    logic [7:0]            clean_reg, clean_next;
    logic [DATA_WIDTH-1:0] syndrome_reg, syndrome_next;
    logic                  mismatch_reg;
    logic                  alarm_reg;
    logic                  suspect_reg;
    logic [7:0]            fault_count_reg;

    logic [DATA_WIDTH-1:0] delayed_data;
    logic                  delayed_valid;
    logic                  armed;
    logic                  compare_en;
    logic                  valid_diff;
    logic                  data_diff;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_syndrome;
    logic [3:0]            streak_inc;

    // Disabled cycles push bubbles so stale samples never reach the compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) begin
                line_data_reg[i]  <= '0;
                line_valid_reg[i] <= 1'b0;
            end
        end else begin
            line_data_reg[0]  <= primary_data;
            line_valid_reg[0] <= enable & primary_valid;
            for (int i = 1; i < DELAY; i++) begin
                line_data_reg[i]  <= line_data_reg[i-1];
                line_valid_reg[i] <= line_valid_reg[i-1];
            end
        end
    end

    assign delayed_data  = line_data_reg[DELAY-1];
    assign delayed_valid = line_valid_reg[DELAY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_count_reg <= '0;
        end else if (!enable) begin
            arm_count_reg <= '0;
        end else if (!armed) begin
            arm_count_reg <= arm_count_reg + 4'd1;
        end
    end

    assign armed        = (arm_count_reg == ARM_DONE);
    assign compare_en   = enable & armed;
    assign valid_diff   = delayed_valid ^ shadow_valid;
    assign data_diff    = delayed_valid & shadow_valid & (delayed_data != shadow_data);
    assign hit          = compare_en & (valid_diff | data_diff);
    assign hit_syndrome = valid_diff ? '1 : (delayed_data ^ shadow_data);
    assign streak_inc   = streak_reg + 4'd1;

    // Clear wins over any same-cycle mismatch for the episode state.
    always_comb begin
        state_next    = state_reg;
        streak_next   = streak_reg;
        clean_next    = clean_reg;
        syndrome_next = syndrome_reg;
        if (clear) begin
            state_next    = enable ? MONITOR : IDLE;
            streak_next   = '0;
            clean_next    = '0;
            syndrome_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) state_next = MONITOR;
                end
                MONITOR: begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (hit) begin
                        streak_next   = 4'd1;
                        clean_next    = '0;
                        syndrome_next = hit_syndrome;
                        state_next    = (THRESHOLD <= 1) ? ALARM : SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (!enable) begin
                        state_next  = IDLE;
                        streak_next = '0;
                        clean_next  = '0;
                    end else if (hit) begin
                        streak_next = streak_inc;
                        clean_next  = '0;
                        if (streak_inc >= THRESH_L) state_next = ALARM;
                    end else if (compare_en) begin
                        if (clean_reg == WINDOW_LAST) begin
                            state_next  = MONITOR;
                            streak_next = '0;
                            clean_next  = '0;
                        end else begin
                            clean_next = clean_reg + 8'd1;
                        end
                    end
                end
                ALARM: begin
                    state_next = ALARM;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            streak_reg      <= '0;
            clean_reg       <= '0;
            syndrome_reg    <= '0;
            mismatch_reg    <= 1'b0;
            alarm_reg       <= 1'b0;
            suspect_reg     <= 1'b0;
            fault_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            streak_reg   <= streak_next;
            clean_reg    <= clean_next;
            syndrome_reg <= syndrome_next;
            mismatch_reg <= hit;
            alarm_reg    <= (state_next == ALARM);
            suspect_reg  <= (state_next == SUSPECT);
            if (hit && fault_count_reg != 8'hFF) begin
                fault_count_reg <= fault_count_reg + 8'd1;
            end
        end
    end

    assign mismatch    = mismatch_reg;
    assign alarm       = alarm_reg;
    assign suspect     = suspect_reg;
    assign fault_count = fault_count_reg;
    assign syndrome    = syndrome_reg;

endmodule

// File: tb/tb_glitch_detector.sv
// Directed bench for glitch_detector: lagged shadow stream with planted
// corruptions, escalation, clear collision, re-arm and asynchronous reset.
module tb_glitch_detector;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] primary_data = '0;
    logic          primary_valid = 1'b0;
    logic [DW-1:0] shadow_data = '0;
    logic          shadow_valid = 1'b0;
    logic          clear = 1'b0;
    logic          mismatch;
    logic          alarm;
    logic          suspect;
    logic [7:0]    fault_count;
    logic [DW-1:0] syndrome;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] seq = 32'd1;
    logic [31:0] hist_d [2];
    logic        hist_v [2];

    glitch_detector #(
        .DATA_WIDTH(DW),
        .DELAY(2),
        .THRESHOLD(3),
        .WINDOW(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .primary_data(primary_data),
        .primary_valid(primary_valid),
        .shadow_data(shadow_data),
        .shadow_valid(shadow_valid),
        .clear(clear),
        .mismatch(mismatch),
        .alarm(alarm),
        .suspect(suspect),
        .fault_count(fault_count),
        .syndrome(syndrome)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("vec %0d %s: 0x%08h ok", vectors, tag, got);
        end
    endtask

    // One enabled stream cycle: shadow carries the primary sample from two cycles ago.
    task automatic stream(input logic [31:0] flip, input logic drop, input logic garbage,
                          input logic clr);
        primary_data  = seq;
        primary_valid = 1'b1;
        if (garbage) begin
            shadow_data  = $urandom;
            shadow_valid = 1'b1;
        end else begin
            shadow_data  = hist_d[1] ^ flip;
            shadow_valid = hist_v[1] & ~drop;
        end
        clear     = clr;
        hist_d[1] = hist_d[0];
        hist_v[1] = hist_v[0];
        hist_d[0] = seq;
        hist_v[0] = 1'b1;
        seq       = seq + 32'd1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic garbage_cycle();
        enable        = 1'b0;
        primary_data  = $urandom;
        primary_valid = 1'($urandom);
        shadow_data   = $urandom;
        shadow_valid  = 1'($urandom);
        hist_d[1]     = hist_d[0];
        hist_v[1]     = hist_v[0];
        hist_d[0]     = primary_data;
        hist_v[0]     = primary_valid;
        @(negedge clk);
    endtask

    initial begin
        int bad;
        hist_d[0] = '0; hist_d[1] = '0;
        hist_v[0] = 1'b0; hist_v[1] = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_suspect", 32'(suspect), 32'd0);
        check("rst_fault_count", 32'(fault_count), 32'd0);
        check("rst_syndrome", syndrome, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Clean run
        enable = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            stream(32'h0, 1'b0, 1'b0, 1'b0);
            if (mismatch || suspect || alarm) bad++;
        end
        check("clean_events", 32'(bad), 32'd0);
        check("clean_fault_count", 32'(fault_count), 32'd0);

        // Single glitch, then recovery after exactly 16 clean compares
        stream(32'h1, 1'b0, 1'b0, 1'b0);
        check("glitch_mismatch", 32'(mismatch), 32'd1);
        check("glitch_syndrome", syndrome, 32'h1);
        check("glitch_suspect", 32'(suspect), 32'd1);
        check("glitch_fault_count", 32'(fault_count), 32'd1);
        stream(32'h0, 1'b0, 1'b0, 1'b0);
        check("glitch_pulse_width", 32'(mismatch), 32'd0);
        for (int i = 0; i < 14; i++) stream(32'h0, 1'b0, 1'b0, 1'b0);
        check("window_15_suspect", 32'(suspect), 32'd1);
        stream(32'h0, 1'b0, 1'b0, 1'b0);
        check("window_16_suspect", 32'(suspect), 32'd0);

        // Escalation: three mismatches within 10 cycles
        stream(32'h10, 1'b0, 1'b0, 1'b0);
        check("esc1_suspect", 32'(suspect), 32'd1);
        check("esc1_syndrome", syndrome, 32'h10);
        for (int i = 0; i < 3; i++) stream(32'h0, 1'b0, 1'b0, 1'b0);
        stream(32'h20, 1'b0, 1'b0, 1'b0);
        check("esc2_alarm", 32'(alarm), 32'd0);
        for (int i = 0; i < 3; i++) stream(32'h0, 1'b0, 1'b0, 1'b0);
        stream(32'h40, 1'b0, 1'b0, 1'b0);
        check("esc3_mismatch", 32'(mismatch), 32'd1);
        check("esc3_alarm", 32'(alarm), 32'd1);
        check("esc3_suspect", 32'(suspect), 32'd0);
        check("esc3_fault_count", 32'(fault_count), 32'd4);
        check("esc3_syndrome", syndrome, 32'h10);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            stream(32'h0, 1'b0, 1'b0, 1'b0);
            if (!alarm) bad++;
        end
        for (int i = 0; i < 3; i++) begin
            garbage_cycle();
            if (!alarm) bad++;
        end
        check("alarm_sticky_drops", 32'(bad), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) stream(32'h0, 1'b0, 1'b0, 1'b0);

        // Clear colliding with a mismatch
        stream(32'h80, 1'b0, 1'b0, 1'b1);
        check("clr_mismatch", 32'(mismatch), 32'd1);
        check("clr_alarm", 32'(alarm), 32'd0);
        check("clr_suspect", 32'(suspect), 32'd0);
        check("clr_fault_count", 32'(fault_count), 32'd5);
        check("clr_syndrome", syndrome, 32'd0);
        stream(32'h0, 1'b0, 1'b0, 1'b0);
        stream(32'h0, 1'b0, 1'b0, 1'b0);
        check("post_clr_alarm", 32'(alarm), 32'd0);

        // Valid-only fault
        stream(32'h0, 1'b1, 1'b0, 1'b0);
        check("vld_mismatch", 32'(mismatch), 32'd1);
        check("vld_syndrome", syndrome, 32'hFFFF_FFFF);
        check("vld_suspect", 32'(suspect), 32'd1);
        check("vld_fault_count", 32'(fault_count), 32'd6);

        // Enable low with garbage, then re-arm
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            garbage_cycle();
            if (mismatch) bad++;
        end
        check("disabled_mismatches", 32'(bad), 32'd0);
        check("disabled_suspect", 32'(suspect), 32'd0);
        enable = 1'b1;
        stream(32'h0, 1'b0, 1'b1, 1'b0);
        check("rearm_edge1_mismatch", 32'(mismatch), 32'd0);
        stream(32'h0, 1'b0, 1'b1, 1'b0);
        check("rearm_edge2_mismatch", 32'(mismatch), 32'd0);
        stream(32'h100, 1'b0, 1'b0, 1'b0);
        check("rearm_edge3_mismatch", 32'(mismatch), 32'd1);
        check("rearm_syndrome", syndrome, 32'h100);
        check("rearm_suspect", 32'(suspect), 32'd1);
        check("rearm_fault_count", 32'(fault_count), 32'd7);

        // Asynchronous reset mid-episode, sampled before the next clock edge
        #2;
        reset = 1'b1;
        #1;
        check("async_mismatch", 32'(mismatch), 32'd0);
        check("async_alarm", 32'(alarm), 32'd0);
        check("async_suspect", 32'(suspect), 32'd0);
        check("async_fault_count", 32'(fault_count), 32'd0);
        check("async_syndrome", syndrome, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
